// File: rtl/crypt_sequencer.sv
// Multi-cycle rotate/xor crypt unit for the decode stage.
// Holds the pipeline while the rounds run, then presents one writeback pulse.
module crypt_sequencer #(
    parameter int ROUNDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        kill,
    output logic        stall,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [4:0]  round_idx
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] RLAST = 5'(ROUNDS - 1);

    logic [1:0]  state;
    logic [31:0] state_reg;
    logic [31:0] key_reg;
    logic        mode;
    logic [4:0]  rnd;
    logic        start;
    logic        last;
    logic [31:0] rkey;
    logic [31:0] enc_nxt;
    logic [31:0] dec_nxt;
    logic [31:0] mix;

    function automatic logic [31:0] rotl(input logic [31:0] x,
                                         input logic [4:0]  n);
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    assign start = instr_valid && (opcode == 6'h00) &&
                   ((funct == 6'h30) || (funct == 6'h31));

    // mode 1 = decrypt, which walks the round keys backwards
    assign last    = mode ? (rnd == 5'd0) : (rnd == RLAST);
    assign rkey    = rotl(key_reg, rnd);
    assign mix     = state_reg ^ rkey;
    assign enc_nxt = {mix[28:0], mix[31:29]};
    assign dec_nxt = {state_reg[2:0], state_reg[31:3]} ^ rkey;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            state_reg <= 32'h0;
            key_reg   <= 32'h0;
            mode      <= 1'b0;
            rnd       <= 5'd0;
        end else if (kill) begin
            state <= S_IDLE;
            rnd   <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        state_reg <= rs_data;
                        key_reg   <= rt_data;
                        mode      <= funct[0];
                        rnd       <= funct[0] ? RLAST : 5'd0;
                    end
                end
                S_RUN: begin
                    state_reg <= mode ? dec_nxt : enc_nxt;
                    rnd       <= mode ? rnd - 5'd1 : rnd + 5'd1;
                    if (last) state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    rnd   <= 5'd0;
                end
                default: begin
                    state <= S_IDLE;
                    rnd   <= 5'd0;
                end
            endcase
        end
    end

    assign stall        = ((state == S_IDLE) && start) || (state == S_RUN);
    assign busy         = (state == S_RUN);
    assign result_valid = (state == S_DONE);
    assign result       = state_reg;
    assign round_idx    = rnd;

endmodule

// File: tb/tb_crypt_sequencer.sv
// Scoreboard bench for crypt_sequencer: random and directed crypt ops
// checked against a loop-level reference model.
module tb_crypt_sequencer;

    localparam int R = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        sv = 1'b0;
    logic [5:0]  opcode = 6'h0;
    logic [5:0]  funct = 6'h0;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] rt_data = 32'h0;
    logic        kill = 1'b0;

    logic        stall, busy, rv;
    logic [31:0] result;
    logic [4:0]  ridx;
    logic        st1, bz1, rv1, st2, bz2, rv2;
    logic [31:0] res1, res2;
    logic [4:0]  ri1, ri2;

    int nchk = 0;
    int nfail = 0;
    logic [31:0] q8[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    always #5 clk = ~clk;

    crypt_sequencer #(.ROUNDS(R)) u8 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
        .opcode(opcode), .funct(funct), .rs_data(rs_data),
        .rt_data(rt_data), .kill(kill), .stall(stall), .busy(busy),
        .result_valid(rv), .result(result), .round_idx(ridx));

    crypt_sequencer #(.ROUNDS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .instr_valid(sv),
        .opcode(opcode), .funct(funct), .rs_data(rs_data),
        .rt_data(rt_data), .kill(kill), .stall(st1), .busy(bz1),
        .result_valid(rv1), .result(res1), .round_idx(ri1));

    crypt_sequencer #(.ROUNDS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .instr_valid(sv),
        .opcode(opcode), .funct(funct), .rs_data(rs_data),
        .rt_data(rt_data), .kill(kill), .stall(st2), .busy(bz2),
        .result_valid(rv2), .result(res2), .round_idx(ri2));

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    // Reference: encrypt applies rounds 0..n-1, decrypt undoes n-1..0
    function automatic logic [31:0] model(input logic [31:0] d,
                                          input logic [31:0] k,
                                          input bit dec, input int n);
        logic [31:0] s;
        s = d;
        if (!dec) begin
            for (int r = 0; r < n; r++) s = rl(s ^ rl(k, r), 3);
        end else begin
            for (int r = n - 1; r >= 0; r--) s = rl(s, 29) ^ rl(k, r);
        end
        return s;
    endfunction

    always @(negedge clk) begin
        if (rst_n && rv) begin
            if (q8.size() == 0) check("u8 unexpected valid", 32'd1, 32'd0);
            else check("u8 result", result, q8.pop_front());
        end
        if (rst_n && rv1) begin
            if (q1.size() == 0) check("u1 unexpected valid", 32'd1, 32'd0);
            else check("u1 result", res1, q1.pop_front());
        end
        if (rst_n && rv2) begin
            if (q2.size() == 0) check("u2 unexpected valid", 32'd1, 32'd0);
            else check("u2 result", res2, q2.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one crypt op and check stall length, round_idx and valid timing
    task automatic issue(input logic [31:0] d, input logic [31:0] k,
                         input bit dec, input logic [31:0] exp);
        int i;
        @(negedge clk);
        instr_valid = 1'b1;
        opcode = 6'h00;
        funct = dec ? 6'h31 : 6'h30;
        rs_data = d;
        rt_data = k;
        q8.push_back(exp);
        #1;
        check("stall at start", {31'd0, stall}, 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        i = 1;
        while (stall && i < 40) begin
            check("busy in run", {31'd0, busy}, 32'd1);
            check("round_idx", {27'd0, ridx},
                  dec ? 32'(R - i) : 32'(i - 1));
            i++;
            @(negedge clk);
        end
        check("stall cycles", i, R + 1);
        check("valid after stall", {31'd0, rv}, 32'd1);
        @(negedge clk);
        check("idle after done", {31'd0, busy | rv}, 32'd0);
    endtask

    task automatic start_only(input logic [31:0] d, input logic [31:0] k);
        @(negedge clk);
        instr_valid = 1'b1;
        opcode = 6'h00;
        funct = 6'h30;
        rs_data = d;
        rt_data = k;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] d, k, e;
        bit dec;

        idle(3);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset valid", {31'd0, rv}, 32'd0);
        check("reset result", result, 32'h0);
        check("reset round_idx", {27'd0, ridx}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        issue(32'h1, 32'h0, 1'b0, 32'h01000000);
        issue(32'h12345678, 32'hCAFEBABE, 1'b0,
              model(32'h12345678, 32'hCAFEBABE, 1'b0, R));
        e = model(32'h12345678, 32'hCAFEBABE, 1'b0, R);
        issue(e, 32'hCAFEBABE, 1'b1, 32'h12345678);

        for (int n = 0; n < 16; n++) begin
            d = $urandom;
            k = $urandom;
            dec = 1'($urandom_range(0, 1));
            issue(d, k, dec, model(d, k, dec, R));
        end
        idle(1);
        check("result holds in idle", result, q8.size() == 0 ?
              model(d, k, dec, R) : 32'hx);

        // kill on the third RUN cycle
        start_only(32'hA5A5A5A5, 32'h5A5A5A5A);
        idle(1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill stall", {31'd0, stall}, 32'd0);
        check("kill busy", {31'd0, busy}, 32'd0);
        check("kill round_idx", {27'd0, ridx}, 32'd0);
        idle(12);

        // kill beats start in IDLE
        @(negedge clk);
        instr_valid = 1'b1;
        funct = 6'h30;
        kill = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        kill = 1'b0;
        check("kill over start", {31'd0, busy}, 32'd0);
        idle(3);

        // reset on the fourth RUN cycle
        start_only(32'hDEADBEEF, 32'h01234567);
        idle(2);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst stall", {31'd0, stall}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst result", result, 32'h0);
        check("rst round_idx", {27'd0, ridx}, 32'd0);
        rst_n = 1'b1;
        idle(12);
        issue(32'h0BADF00D, 32'h13579BDF, 1'b0,
              model(32'h0BADF00D, 32'h13579BDF, 1'b0, R));

        // start held through DONE: exactly one writeback
        @(negedge clk);
        instr_valid = 1'b1;
        opcode = 6'h00;
        funct = 6'h30;
        rs_data = 32'h00C0FFEE;
        rt_data = 32'h77777777;
        q8.push_back(model(32'h00C0FFEE, 32'h77777777, 1'b0, R));
        idle(R + 2);
        instr_valid = 1'b0;
        idle(15);
        check("held start one pulse", q8.size(), 32'd0);

        // non-crypt opcode and invalid slots never stall
        opcode = 6'h23;
        funct = 6'h30;
        instr_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            #1;
            check("opcode 23 stall", {31'd0, stall | busy}, 32'd0);
        end
        opcode = 6'h00;
        funct = 6'h31;
        instr_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            #1;
            check("invalid stall", {31'd0, stall | busy}, 32'd0);
        end

        // short-round instances
        @(negedge clk);
        sv = 1'b1;
        opcode = 6'h00;
        funct = 6'h30;
        rs_data = 32'h0;
        rt_data = 32'hFFFFFFFF;
        q1.push_back(32'hFFFFFFFF);
        q2.push_back(32'h00000000);
        @(negedge clk);
        sv = 1'b0;
        idle(6);
        check("u1 result holds", res1, 32'hFFFFFFFF);

        idle(2);
        check("u8 queue drained", q8.size(), 32'd0);
        check("u1 queue drained", q1.size(), 32'd0);
        check("u2 queue drained", q2.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/crypt_sequencer.md
CRYPT_SEQUENCER -- requirements
Module: crypt_sequencer

Interface
REQ-001 Parameter ROUNDS, default 8, SHALL set the number of cipher rounds per crypt instruction; legal range 1..31.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-004 instr_valid  input  1  SHALL qualify opcode/funct as the instruction currently in decode.
REQ-005 opcode  input  6  SHALL carry the instruction opcode field.
REQ-006 funct  input  6  SHALL carry the instruction funct field.
REQ-007 rs_data  input  32  SHALL carry the data operand (plaintext or ciphertext).
REQ-008 rt_data  input  32  SHALL carry the key operand.
REQ-009 kill  input  1  SHALL abort any crypt operation in progress.
REQ-010 stall  output  1  SHALL freeze PC and register-file writes while high.
REQ-011 busy  output  1  SHALL be high while in RUN.
REQ-012 result_valid  output  1  SHALL pulse high for one cycle when result is ready for writeback.
REQ-013 result  output  32  SHALL carry the crypt result (the writeback source for crypt instructions).
REQ-014 round_idx  output  5  SHALL carry the current round number, for debug.

Function
REQ-015 Decode: start = instr_valid & opcode==0x00 & (funct==0x30 | funct==0x31); funct 0x30 SHALL mean encrypt and 0x31 decrypt.
REQ-016 FSM states: IDLE, RUN, DONE.
REQ-017 IDLE with start: latch state_reg=rs_data, key_reg=rt_data, mode=funct[0]; set round counter to 0 (encrypt) or ROUNDS-1 (decrypt); next state RUN.
REQ-018 IDLE without start: remain in IDLE; registers hold.
REQ-019 RUN, encrypt, round r: state_reg <= rotl(state_reg ^ rotl(key_reg, r), 3); r increments.
REQ-020 RUN, decrypt, round r: state_reg <= rotr(state_reg, 3) ^ rotl(key_reg, r); r decrements.
REQ-021 All rotates SHALL be 32-bit circular, and the amount r SHALL be taken mod 32.
REQ-022 RUN SHALL last exactly ROUNDS cycles, then go to DONE.
REQ-023 DONE: result_valid=1 and stall=0 for one cycle; the next state SHALL be IDLE unconditionally; start SHALL be ignored in DONE, so the same instruction is not re-triggered.
REQ-024 stall SHALL be combinational: stall = (IDLE & start) | RUN.
REQ-025 Latency: start seen in cycle T -> stall high for cycles T..T+ROUNDS (ROUNDS+1 cycles), and result_valid in cycle T+ROUNDS+1.
REQ-026 result SHALL equal state_reg at all times, and SHALL hold its last value in IDLE.
REQ-027 busy = (state==RUN); round_idx = current round counter, and 0 in IDLE.
REQ-028 kill in any state SHALL force IDLE on the next edge with no result_valid; stall SHALL drop in the kill cycle's next cycle; kill has priority over start.
REQ-029 Non-crypt instructions, and instr_valid low, SHALL never assert stall.

Reset
REQ-030 rst_n low at an edge SHALL force IDLE, state_reg=0, key_reg=0, mode=0 and round counter=0, in every state including mid-RUN.
REQ-031 During and after reset: stall=0, busy=0, result_valid=0, result=0x00000000, round_idx=0.
REQ-032 Reset SHALL take priority over kill and start.

Verification
REQ-033 ROUNDS=8, encrypt, rs=0x00000001, rt=0x00000000 -> stall high 9 cycles, result_valid on 10th cycle, result=0x01000000.
REQ-034 ROUNDS=2, encrypt, rs=0x00000000, rt=0xFFFFFFFF -> result=0x00000000; ROUNDS=1, same operands -> result=0xFFFFFFFF.
REQ-035 ROUNDS=8, encrypt rs=0x12345678, rt=0xCAFEBABE, then decrypt its result with the same key -> second result=0x12345678.
REQ-036 rst_n low at cycle 4 of RUN -> next cycle IDLE, stall=0, result=0; no result_valid pulse; a following start runs normally.
REQ-037 kill at cycle 3 of RUN -> IDLE next cycle, no result_valid; start held through DONE -> exactly one result_valid pulse; opcode=0x23 -> stall never asserted.
